// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transmitter.
// Latency: n/a (definitions only).
// Backpressure: n/a. Optional even-parity state is compiled in by UART_TX_PARITY_EN.
package uart_pkg;

    localparam int UBRR_W = 12;
    localparam int DATA_W = 8;
    localparam int OSR    = 16;

    localparam int SUB_W  = $clog2(OSR);
    localparam int IDX_W  = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick divider: one tick every ubrr+1 clocks, counter restarts at 0 while clear is high.
// Latency: first tick ubrr+1 clocks after clear drops.
// Backpressure: none; free-running while clear is low.
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [UBRR_W-1:0] ubrr,
    output logic              tick
);

    logic [UBRR_W-1:0] cnt_q;

    // Count 0..ubrr and wrap; the terminal count fits in UBRR_W bits, so 4095 cannot overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear || (cnt_q == ubrr)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + UBRR_W'(1);
        end
    end

    // Tick is suppressed while held in clear so an idle transmitter sees no stray tick.
    always_comb begin
        tick = !clear && (cnt_q == ubrr);
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined), LSB first, 16 ticks per bit.
// Latency: tx goes low the cycle after accept; tx_done pulses 10 (11 with parity) bit periods later.
// Backpressure: tx_start is only sampled in IDLE; requests while busy are ignored, not queued.
module uart_tx
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [UBRR_W-1:0] ubrr,
    input  logic [DATA_W-1:0] data_i,
    input  logic              tx_start,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] data_q;
    logic [UBRR_W-1:0] ubrr_q;
    logic [SUB_W-1:0]  sub_q;
    logic [IDX_W-1:0]  idx_q;
    logic              done_q;

    logic              tick;
    logic              bit_end;
    logic              accept;
    logic              baud_clear;

    // Divider is held at zero in IDLE, so it restarts cleanly on the accept edge.
    assign baud_clear = (state_q == IDLE);

    uart_baud_gen u_baud_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .ubrr  (ubrr_q),
        .tick  (tick)
    );

    assign accept  = (state_q == IDLE) && tx_start;
    assign bit_end = tick && (sub_q == SUB_W'(OSR - 1));

    // State register; reset returns to IDLE immediately, aborting any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: each non-idle state lasts exactly one bit period.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (tx_start) state_d = START;
            START:  if (bit_end)  state_d = DATA;
            DATA: begin
                if (bit_end && (idx_q == IDX_W'(DATA_W - 1))) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end)  state_d = STOP;
`endif
            STOP:   if (bit_end)  state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Line driver decoded from registered state so reset forces the line high without a clock.
    always_comb begin
        tx   = 1'b1;
        busy = (state_q != IDLE);
        case (state_q)
            START:  tx = 1'b0;
            DATA:   tx = data_q[idx_q];
`ifdef UART_TX_PARITY_EN
            PARITY: tx = ^data_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    // Frame datapath: inputs are captured once at accept and never looked at again mid-frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            ubrr_q <= '0;
            sub_q  <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == STOP) && bit_end;
            if (accept) begin
                data_q <= data_i;
                ubrr_q <= ubrr;
                sub_q  <= '0;
                idx_q  <= '0;
            end else if (tick) begin
                sub_q <= sub_q + SUB_W'(1);
                if (bit_end && (state_q == DATA)) begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

    assign tx_done = done_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have port clk  input  1  system clock, 3.6864 MHz nominal.
REQ-002 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port ubrr  input  12  baud divisor; bit period = 16*(ubrr+1) clk cycles (23 -> 9600 baud).
REQ-004 SHALL have port data_i  input  8  byte to transmit, level-held by the upstream ROM stage.
REQ-005 SHALL have port tx_start  input  1  request to send data_i, active-high, level-sampled.
REQ-006 SHALL have port tx  output  1  serial line, idle high, LSB first.
REQ-007 SHALL have port busy  output  1  high while a frame is in progress.
REQ-008 SHALL have port tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-009 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; PARITY only when parity is compiled in (see Configuration).
REQ-010 SHALL accept a request on the rising edge where the state is IDLE and tx_start=1; it SHALL latch data_i and ubrr into internal registers on that edge.
REQ-011 SHALL, on the accept edge, enter START with busy=1 and tx=0 visible in the following cycle.
REQ-012 SHALL ignore tx_start whenever the state is not IDLE; input changes mid-frame SHALL NOT affect the frame.
REQ-013 SHALL derive a baud tick from a 12-bit counter that counts 0..latched ubrr, restarts at 0 on accept, and produces one tick per ubrr+1 clocks.
REQ-014 SHALL make each bit 16 ticks long, counted by a 4-bit sub-bit counter that wraps 15->0.
REQ-015 SHALL, in START, drive tx=0 for one bit, then enter DATA.
REQ-016 SHALL, in DATA, drive bit[0] first through bit[7] last, using a 3-bit index, one bit period each; after index 7, go to PARITY if compiled in, otherwise to STOP.
REQ-017 SHALL, in STOP, drive tx=1 for one bit; at its end, return to IDLE with busy=0 and tx_done=1 for exactly one cycle.
REQ-018 SHALL make the frame length from accept to tx_done exactly 10*16*(ubrr+1) clocks without parity and 11*16*(ubrr+1) with parity; ubrr=23 gives 3840 and 4224.
REQ-019 SHALL support ubrr=0 as a legal value (tick every clock, 16-clock bits); ubrr=4095 SHALL produce 65536-clock bits with no counter overflow.
REQ-020 SHALL accept a new frame on the first cycle after tx_done if tx_start=1, giving a minimum inter-frame idle of one clock.
REQ-021 SHALL drive tx high in IDLE at all times.

Reset
REQ-022 SHALL, while rst=0, immediately force tx=1, busy=0, tx_done=0, state=IDLE, and all counters and latches to 0.
REQ-023 SHALL, on reset asserted mid-frame, abort the frame without a tx_done pulse and return tx high asynchronously.
REQ-024 SHALL NOT accept tx_start until the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL compile in an even-parity bit only when macro UART_TX_PARITY_EN is defined.
REQ-026 SHALL, with UART_TX_PARITY_EN defined, transmit one PARITY bit equal to the XOR of the 8 latched data bits, placed between bit[7] and stop.
REQ-027 SHALL, without UART_TX_PARITY_EN, contain no parity state or logic; DATA goes directly to STOP.

Structure
REQ-028 SHALL place the FSM state encoding and the width constants (UBRR_W=12, DATA_W=8, OSR=16) in the shared package uart_pkg.
REQ-029 SHALL implement the tick divider as sub-module uart_baud_gen (inputs clk, rst, clear, ubrr; output tick); all other logic stays in uart_tx.

Verification
REQ-030 SHALL cover: ubrr=23, data_i=0x41, tx_start pulse -> tx low 384 clocks, then bits 1,0,0,0,0,0,1,0 at 384 clocks each, stop high, tx_done at clock 3840.
REQ-031 SHALL cover: UART_TX_PARITY_EN defined, data_i=0x42 -> parity bit 0; data_i=0x43 -> parity bit 1; tx_done at 4224 clocks.
REQ-032 SHALL cover: tx_start held high continuously, ubrr=0 -> back-to-back 160-clock frames separated by exactly one idle-high clock.
REQ-033 SHALL cover: data_i changed 0x41->0x42 and ubrr changed 23->11 mid-frame -> current frame unchanged (0x41, 384-clock bits).
REQ-034 SHALL cover: rst pulsed low at clock 1000 of a frame -> tx=1, busy=0 asynchronously and no tx_done pulse; a fresh request afterwards sends a correct full frame.
